iccm_boot_loader: RTL and testbench



---
 rtl/iccm_boot_loader_pkg.sv | 8 +
 rtl/iccm_boot_loader_word_packer.sv | 37 +++
 rtl/iccm_boot_loader.sv | 118 +++++++++++
 tb/tb_iccm_boot_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_boot_loader_pkg.sv
// iccm_boot_loader_pkg: shared types and constants for the ICCM boot loader
package iccm_boot_loader_pkg;
    localparam int TL_DW = 32;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int HDR_BYTES = 4;
    typedef enum logic [2:0] {ST_SYNC, ST_HDR, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_HDR, ERR_CSUM, ERR_TIMEOUT} err_code_e;
endpackage

// File: rtl/iccm_boot_loader_word_packer.sv
// iccm_boot_loader_word_packer: little-endian byte-to-word assembly with running checksum
module iccm_boot_loader_word_packer
    import iccm_boot_loader_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       data,
    output logic             word_valid,
    output logic [TL_DW-1:0] word,
    output logic [7:0]       csum
);
    logic [1:0]  idx_q;
    logic [23:0] acc_q;
    logic [7:0]  csum_q;

    // The 4th byte completes the word combinationally so the writer can register it on acceptance
    assign word_valid = en && idx_q == 2'd3;
    assign word       = {data, acc_q};
    assign csum       = csum_q;

    // Collect the lower three bytes, track byte position and accumulate the checksum
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            idx_q  <= '0;
            acc_q  <= '0;
            csum_q <= '0;
        end else if (en) begin
            idx_q        <= idx_q + 1'b1;
            csum_q       <= csum_q + data;
            acc_q[7:0]   <= idx_q == 2'd0 ? data : acc_q[7:0];
            acc_q[15:8]  <= idx_q == 2'd1 ? data : acc_q[15:8];
            acc_q[23:16] <= idx_q == 2'd2 ? data : acc_q[23:16];
        end
    end
endmodule

// File: rtl/iccm_boot_loader.sv
// iccm_boot_loader: framed byte-stream loader that fills the ICCM and releases the core
module iccm_boot_loader
    import iccm_boot_loader_pkg::*;
#(
    parameter int         AW             = 11,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             iccm_we_no,
    output logic [TL_DW-1:0] iccm_wdata_o,
    output logic [TL_DW-1:0] iccm_wmask_o,
    output logic [AW-1:0]    iccm_waddr_o,
    output logic             mem_finish_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    err_code_e         code_q, code_d;
    logic              accept, active, hdr_last, hdr_bad, timeout, wr, word_valid;
    logic [TL_DW-1:0]  word;
    logic [7:0]        csum, cnt_lo_q;
    logic [1:0]        hidx_q;
    logic [15:0]       addr_q, hdr_cnt, rem_q;
    logic [AW-1:0]     ptr_q;
    logic [IW-1:0]     idle_q;

    assign accept     = byte_valid_i & byte_ready_o;
    assign active     = state_q inside {ST_HDR, ST_DATA, ST_CSUM};
    assign hdr_cnt    = {byte_data_i, cnt_lo_q};
    assign hdr_last   = accept && state_q == ST_HDR && hidx_q == 2'(HDR_BYTES - 1);
    assign hdr_bad    = hdr_cnt == '0 || (addr_q >> AW) != '0 ||
                        ({1'b0, addr_q} + {1'b0, hdr_cnt}) > 17'(2 ** AW);
    assign timeout    = active && !accept && idle_q == IW'(TIMEOUT_CYCLES - 1);
    assign wr         = state_q == ST_DATA && word_valid;
    assign err_code_o = code_q;

    iccm_boot_loader_word_packer u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr        (state_q == ST_SYNC),
        .en         (accept && state_q == ST_DATA),
        .data       (byte_data_i),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_SYNC;
        else       state_q <= state_d;
    end

    // Next-state and error classification; the header is judged as its last byte arrives
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: if (accept && byte_data_i == SYNC_BYTE) state_d = ST_HDR;
            ST_HDR:  if (hdr_last) state_d = hdr_bad ? ST_ERR : ST_DATA;
            ST_DATA: if (wr && rem_q == 16'd1) state_d = ST_CSUM;
            ST_CSUM: if (accept) state_d = byte_data_i == csum ? ST_DONE : ST_ERR;
            default: ;
        endcase
        if (timeout) state_d = ST_ERR;
        code_d = (state_d == ST_ERR && state_q != ST_ERR) ?
                 (timeout ? ERR_TIMEOUT : state_q == ST_HDR ? ERR_HDR : ERR_CSUM) : code_q;
    end

    // Header capture, word pointer, idle timer and registered ICCM/status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_ready_o <= 1'b0;
            iccm_we_no   <= 1'b1;
            iccm_wdata_o <= '0;
            iccm_wmask_o <= '0;
            iccm_waddr_o <= '0;
            mem_finish_o <= 1'b0;
            err_o        <= 1'b0;
            code_q       <= ERR_NONE;
            hidx_q       <= '0;
            addr_q       <= '0;
            cnt_lo_q     <= '0;
            rem_q        <= '0;
            ptr_q        <= '0;
            idle_q       <= '0;
        end else begin
            byte_ready_o <= !(state_d inside {ST_DONE, ST_ERR});
            mem_finish_o <= state_d == ST_DONE;
            err_o        <= state_d == ST_ERR;
            code_q       <= code_d;
            iccm_we_no   <= !wr;
            idle_q       <= (active && !accept) ? idle_q + 1'b1 : '0;
            if (state_q == ST_SYNC) hidx_q <= '0;
            else if (accept && state_q == ST_HDR) hidx_q <= hidx_q + 1'b1;
            if (accept && state_q == ST_HDR && hidx_q == 2'd0) addr_q[7:0]  <= byte_data_i;
            if (accept && state_q == ST_HDR && hidx_q == 2'd1) addr_q[15:8] <= byte_data_i;
            if (accept && state_q == ST_HDR && hidx_q == 2'd2) cnt_lo_q     <= byte_data_i;
            if (hdr_last) begin
                ptr_q <= addr_q[AW-1:0];
                rem_q <= hdr_cnt;
            end
            if (wr) begin
                iccm_wdata_o <= word;
                iccm_wmask_o <= '1;
                iccm_waddr_o <= ptr_q;
                ptr_q        <= ptr_q + 1'b1;
                rem_q        <= rem_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iccm_boot_loader.sv
// tb_iccm_boot_loader: directed self-checking bench for the ICCM boot loader
module tb_iccm_boot_loader;
    import iccm_boot_loader_pkg::*;

    localparam int AW = 11;
    localparam int TO = 16;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             byte_valid_i = 1'b0;
    logic [7:0]       byte_data_i = 8'h00;
    logic             byte_ready_o, iccm_we_no, mem_finish_o, err_o;
    logic [TL_DW-1:0] iccm_wdata_o, iccm_wmask_o;
    logic [AW-1:0]    iccm_waddr_o;
    logic [1:0]       err_code_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] wm_q[$];
    logic [31:0] pw [16];
    logic [7:0]  cs;

    iccm_boot_loader #(.AW(AW), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .iccm_we_no   (iccm_we_no),
        .iccm_wdata_o (iccm_wdata_o),
        .iccm_wmask_o (iccm_wmask_o),
        .iccm_waddr_o (iccm_waddr_o),
        .mem_finish_o (mem_finish_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Log every write strobe seen mid-cycle; a stretched strobe shows up as extra entries
    always @(negedge clk_i) begin
        if (!iccm_we_no) begin
            wa_q.push_back(32'(iccm_waddr_o));
            wd_q.push_back(iccm_wdata_o);
            wm_q.push_back(iccm_wmask_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        @(posedge clk_i);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] a, input logic [15:0] c);
        send(8'hA5);
        send(a[7:0]);
        send(a[15:8]);
        send(c[7:0]);
        send(c[15:8]);
        cs = 8'h00;
    endtask

    task automatic send_words(input int first, input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = pw[first + i];
            for (int k = 0; k < 4; k++) begin
                cs = cs + w[8*k +: 8];
                send(w[8*k +: 8]);
            end
        end
    endtask

    task automatic clear_log;
        wa_q.delete();
        wd_q.delete();
        wm_q.delete();
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        clear_log();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_rst(input string p);
        check({p, ".ready"}, 32'(byte_ready_o), 32'd0);
        check({p, ".we_n"},  32'(iccm_we_no), 32'd1);
        check({p, ".wdata"}, iccm_wdata_o, 32'd0);
        check({p, ".wmask"}, iccm_wmask_o, 32'd0);
        check({p, ".waddr"}, 32'(iccm_waddr_o), 32'd0);
        check({p, ".finish"}, 32'(mem_finish_o), 32'd0);
        check({p, ".err"},   32'(err_o), 32'd0);
        check({p, ".code"},  32'(err_code_o), 32'd0);
    endtask

    task automatic check_end(input string p, input logic fin, input logic err, input logic [1:0] code);
        repeat (2) @(posedge clk_i);
        #1;
        check({p, ".finish"}, 32'(mem_finish_o), 32'(fin));
        check({p, ".err"},    32'(err_o), 32'(err));
        check({p, ".code"},   32'(err_code_o), 32'(code));
        check({p, ".ready"},  32'(byte_ready_o), (fin | err) ? 32'd0 : 32'd1);
    endtask

    task automatic check_writes(input string p, input logic [31:0] base, input int first, input int n);
        check({p, ".nwr"}, 32'(wa_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wa_q.size()) begin
                check({p, ".waddr"}, wa_q[i], base + 32'(i));
                check({p, ".wdata"}, wd_q[i], pw[first + i]);
                check({p, ".wmask"}, wm_q[i], 32'hFFFF_FFFF);
            end
        end
    endtask

    // Directed test sequence
    initial begin
        pw[0]  = 32'h40000437; pw[1]  = 32'h00a00e13; pw[2]  = 32'h01400e93; pw[3]  = 32'h01de0f33;
        pw[4]  = 32'h01e42423; pw[5]  = 32'h00f00e13; pw[6]  = 32'h01900e93; pw[7]  = 32'h01de0f33;
        pw[8]  = 32'h01e42823; pw[9]  = 32'h00000fff; pw[10] = 32'hDEADBEEF; pw[11] = 32'h12345678;
        pw[12] = 32'h89ABCDEF; pw[13] = 32'h0; pw[14] = 32'h0; pw[15] = 32'h0;
        cs = 8'h00;

        repeat (2) @(posedge clk_i);
        #1;
        check_rst("por");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("por.ready_after", 32'(byte_ready_o), 32'd1);

        send_hdr(16'h0000, 16'd10);
        send_words(0, 10);
        send(cs);
        check_end("load10", 1'b1, 1'b0, 2'd0);
        check_writes("load10", 32'h0, 0, 10);

        do_reset();
        send_hdr(16'h07FF, 16'd1);
        send_words(10, 1);
        send(cs);
        check_end("top1", 1'b1, 1'b0, 2'd0);
        check_writes("top1", 32'h7FF, 10, 1);

        do_reset();
        send_hdr(16'h07FF, 16'd2);
        check_end("top2", 1'b0, 1'b1, 2'd1);
        check_writes("top2", 32'h0, 0, 0);

        do_reset();
        send_hdr(16'h0010, 16'd0);
        check_end("cnt0", 1'b0, 1'b1, 2'd1);
        check_writes("cnt0", 32'h0, 0, 0);

        do_reset();
        send_hdr(16'h0100, 16'd2);
        send_words(11, 2);
        send(cs + 8'd1);
        check_end("badcs", 1'b0, 1'b1, 2'd2);
        check_writes("badcs", 32'h100, 11, 2);

        do_reset();
        send(8'h00);
        send(8'hFF);
        repeat (TO + 4) @(posedge clk_i);
        #1;
        check("sync.err", 32'(err_o), 32'd0);
        check("sync.ready", 32'(byte_ready_o), 32'd1);
        send_hdr(16'h0000, 16'd4);
        send_words(0, 1);
        send(pw[1][7:0]);
        send(pw[1][15:8]);
        repeat (TO - 1) @(posedge clk_i);
        #1;
        check("tmo.early_err", 32'(err_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("tmo.err", 32'(err_o), 32'd1);
        check("tmo.code", 32'(err_code_o), 32'd3);
        check("tmo.ready", 32'(byte_ready_o), 32'd0);
        check_writes("tmo", 32'h0, 0, 1);

        do_reset();
        send_hdr(16'h0020, 16'd3);
        send_words(0, 1);
        check("mid.strobe", 32'(iccm_we_no), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_rst("mid");
        rst_i = 1'b0;
        clear_log();
        @(posedge clk_i);
        #1;
        send_hdr(16'h0020, 16'd3);
        send_words(0, 3);
        send(cs);
        check_end("reload", 1'b1, 1'b0, 2'd0);
        check_writes("reload", 32'h20, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
